dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters.
- Port 0 is the CPU31 load/store path; port 1 is a DMA/debug master.
- Sits between the requesters and DMEM, and drives DMEM's ena/DM_W/DM_R/DM_addr/DM_wdata.
- Round-robin arbitration, plus an optional bounded bus lock for port-1 bursts. A starved CPU stalls via its grant signal.

---
 rtl/dmem_arbiter.sv | 87 ++++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin DMEM sharing between CPU (port 0) and DMA (port 1) with bounded port-1 bus lock
module dmem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              dm_ena,
  output logic              dm_w,
  output logic              dm_r,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic {ARB, LOCK1} state_t;
  state_t            state_q;
  logic              prio_q;
  logic [CW-1:0]     lock_cnt_q;
  logic              rv0_q, rv1_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic              g0, g1;
  // grants are masked by reset so no DMEM access escapes while reset is held low
  always_comb begin
    g0       = reset & m0_req & (state_q == ARB) & (~m1_req | ~prio_q);
    g1       = reset & m1_req & ((state_q == LOCK1) | ~m0_req | prio_q);
    dm_w     = (g0 & m0_we) | (g1 & m1_we);
    dm_r     = (g0 & ~m0_we) | (g1 & ~m1_we);
    dm_ena   = dm_w | dm_r;
    dm_addr  = g0 ? m0_addr : g1 ? m1_addr : '0;
    dm_wdata = g0 ? m0_wdata : g1 ? m1_wdata : '0;
  end
  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB;
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
    end else begin
      rv0_q <= g0 & ~m0_we;
      rv1_q <= g1 & ~m1_we;
      if (g0 & ~m0_we) rd0_q <= dm_rdata;
      if (g1 & ~m1_we) rd1_q <= dm_rdata;
      if (state_q == ARB) begin
        if (g0 | g1) prio_q <= g0;
        if (g1 && m1_lock && MAX_LOCK > 1) begin
          state_q    <= LOCK1;
          lock_cnt_q <= CW'(1);
        end
      end else if (!m1_req || !m1_lock) begin
        state_q <= ARB;
        prio_q  <= 1'b0;
      end else if (lock_cnt_q == CW'(MAX_LOCK - 1)) begin
        state_q    <= ARB;
        prio_q     <= 1'b0;
        lock_cnt_q <= '0;
      end else begin
        lock_cnt_q <= lock_cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioural DMEM
module tb_dmem_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int ML = 4;
  logic          clk_in = 1'b0;
  logic          reset  = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, dm_ena, dm_w, dm_r;
  logic [DW-1:0] m0_rdata, m1_rdata, dm_wdata, dm_rdata;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] x0, x1;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk_in(clk_in), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = mem[dm_addr];
  always @(posedge clk_in) if (dm_w) mem[dm_addr] <= dm_wdata;

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(32'hC0DE_0000 + a);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // v is write data for a write, expected read data for a read
  task automatic req0(input logic r, input logic we, input int a, input logic [DW-1:0] v);
    m0_req = r; m0_we = we; m0_addr = AW'(a);
    m0_wdata = we ? v : '0;
    x0 = v;
  endtask

  task automatic req1(input logic r, input logic we, input int a, input logic [DW-1:0] v);
    m1_req = r; m1_we = we; m1_addr = AW'(a);
    m1_wdata = we ? v : '0;
    x1 = v;
  endtask

  task automatic tick(input logic e0, input logic e1);
    logic ew, er;
    logic [DW-1:0] ea, ed;
    @(negedge clk_in);
    ew = (e0 & m0_we) | (e1 & m1_we);
    er = (e0 & ~m0_we) | (e1 & ~m1_we);
    ea = e0 ? DW'(m0_addr) : e1 ? DW'(m1_addr) : '0;
    ed = e0 ? m0_wdata : e1 ? m1_wdata : '0;
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("dm_w", dm_w, ew);
    chk("dm_r", dm_r, er);
    chk("dm_ena", dm_ena, ew | er);
    chk("dm_addr", DW'(dm_addr), ea);
    chk("dm_wdata", dm_wdata, ed);
    if (e0 & ~m0_we) q0.push_back(x0);
    if (e1 & ~m1_we) q1.push_back(x1);
    @(posedge clk_in);
    #1;
    chk("m0_rvalid", m0_rvalid, q0.size() != 0);
    if (q0.size() != 0) chk("m0_rdata", m0_rdata, q0.pop_front());
    chk("m1_rvalid", m1_rvalid, q1.size() != 0);
    if (q1.size() != 0) chk("m1_rdata", m1_rdata, q1.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_dm_ena", dm_ena, 0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
    #2;
    do_reset();
    // single write then read by port 0
    req0(1, 1, 5, 32'hDEADBEEF); tick(1, 0);
    req0(1, 0, 5, 32'hDEADBEEF); tick(1, 0);
    req0(0, 0, 0, '0);           tick(0, 0);
    // contention round-robin from a fresh reset
    do_reset();
    req0(1, 0, 'h10, pat('h10));
    req1(1, 0, 'h20, pat('h20));
    m1_lock = 1'b0;
    tick(1, 0); tick(0, 1); tick(1, 0); tick(0, 1);
    // lock burst with forced release after MAX_LOCK grants
    req0(0, 0, 0, '0);
    req1(1, 0, 'h40, pat('h40));
    m1_lock = 1'b1;
    tick(0, 1);
    req0(1, 0, 'h30, pat('h30));
    tick(0, 1); tick(0, 1); tick(0, 1);
    tick(1, 0);
    tick(0, 1);
    req0(0, 0, 0, '0);
    req1(0, 0, 0, '0);
    tick(0, 0);
    // voluntary release on second locked grant
    req1(1, 0, 'h41, pat('h41));
    m1_lock = 1'b1;
    tick(0, 1);
    req0(1, 0, 'h31, pat('h31));
    m1_lock = 1'b0;
    tick(0, 1);
    tick(1, 0);
    req0(0, 0, 0, '0);
    tick(0, 1);
    req1(0, 0, 0, '0);
    // write/read ordering across ports
    req0(1, 1, 9, 32'h11);
    req1(1, 0, 9, 32'h11);
    tick(1, 0);
    req0(0, 0, 0, '0);
    tick(0, 1);
    req1(0, 0, 0, '0);
    tick(0, 0);
    // asynchronous reset while locked with a read result outstanding
    req1(1, 0, 9, 32'h11);
    m1_lock = 1'b1;
    tick(0, 1);
    req1(1, 1, 3, 32'hBAD0BAD0);
    #2;
    chk("lock_m1_gnt", m1_gnt, 1);
    chk("lock_dm_w", dm_w, 1);
    reset = 1'b0;
    #1;
    chk("arst_m1_rvalid", m1_rvalid, 0);
    chk("arst_m1_gnt", m1_gnt, 0);
    chk("arst_dm_w", dm_w, 0);
    chk("arst_dm_ena", dm_ena, 0);
    @(posedge clk_in);
    req1(0, 0, 0, '0);
    m1_lock = 1'b0;
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    req0(1, 0, 'h30, pat('h30));
    req1(1, 0, 'h40, pat('h40));
    tick(1, 0);
    req0(1, 0, 3, pat(3));
    tick(0, 1);
    tick(1, 0);
    req0(0, 0, 0, '0);
    req1(0, 0, 0, '0);
    tick(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
